// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: writeback source encoding and pipeline
// controller state.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    REGSRC_ALU = 2'b00,
    REGSRC_NPC = 2'b01,
    REGSRC_LUI = 2'b10,
    REGSRC_MEM = 2'b11
  } regsrc_t;

  typedef enum logic [1:0] {
    RUN    = 2'b00,
    DWAIT  = 2'b01,
    HALTED = 2'b10
  } pctl_state_t;

endpackage

// File: rtl/pipeline_controller_if.sv
// Bundle of the pipeline controller's hazard inputs and latch-control outputs
// for use by the datapath top and its tests.
interface pipeline_controller_if #(parameter int CNT_W = 16);
  logic             ihit, dhit;
  logic             dmemREN_me, dmemWEN_me;
  logic [4:0]       rs_de, rt_de;
  logic             usesRt_de, jr_de, jump_de;
  logic             branch_taken_ex, regWr_ex;
  logic [4:0]       regDst_ex;
  logic [1:0]       regSrc_ex;
  logic             halt_wb;
  logic             pc_en, en_fd, en_de, en_em, en_mw;
  logic             flush_fd, flush_de;
  logic             halted, mem_err;
  logic [CNT_W-1:0] stall_cnt, flush_cnt;

  modport ctrl (
    input  ihit, dhit, dmemREN_me, dmemWEN_me, rs_de, rt_de, usesRt_de,
           jr_de, jump_de, branch_taken_ex, regWr_ex, regDst_ex, regSrc_ex,
           halt_wb,
    output pc_en, en_fd, en_de, en_em, en_mw, flush_fd, flush_de, halted,
           mem_err, stall_cnt, flush_cnt
  );

  modport dp (
    output ihit, dhit, dmemREN_me, dmemWEN_me, rs_de, rt_de, usesRt_de,
           jr_de, jump_de, branch_taken_ex, regWr_ex, regDst_ex, regSrc_ex,
           halt_wb,
    input  pc_en, en_fd, en_de, en_em, en_mw, flush_fd, flush_de, halted,
           mem_err, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/load_use_detect.sv
// Combinational load-use comparator: the EX instruction is a load whose
// destination is read by the decode instruction, so forwarding cannot help.
module load_use_detect
  import cpu_types_pkg::*;
(
  input  logic       regWr_ex,
  input  logic [1:0] regSrc_ex,
  input  logic [4:0] regDst_ex,
  input  logic [4:0] rs_de,
  input  logic [4:0] rt_de,
  input  logic       usesRt_de,
  input  logic       jr_de,
  output logic       lu
);
  logic w_ld_ex;
  logic w_rs_hit;
  logic w_rt_hit;
  logic w_jr_hit;

  assign w_ld_ex  = regWr_ex && (regSrc_ex == REGSRC_MEM) && (regDst_ex != 5'd0);
  assign w_rs_hit = (regDst_ex == rs_de);
  assign w_rt_hit = usesRt_de && (regDst_ex == rt_de);
  // JR reads its target through rs; named separately so the JR-after-load case stays visible
  assign w_jr_hit = jr_de && w_rs_hit;

  assign lu = w_ld_ex && (w_rs_hit || w_rt_hit || w_jr_hit);
endmodule

// File: rtl/pipeline_controller.sv
// Stall/flush sequencer for the 5-stage pipeline: priority decode of latch
// enables/flushes, RUN/DWAIT/HALTED state, DWAIT watchdog and event counters.
module pipeline_controller
  import cpu_types_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dmemREN_me,
  input  logic             dmemWEN_me,
  input  logic [4:0]       rs_de,
  input  logic [4:0]       rt_de,
  input  logic             usesRt_de,
  input  logic             jr_de,
  input  logic             jump_de,
  input  logic             branch_taken_ex,
  input  logic             regWr_ex,
  input  logic [4:0]       regDst_ex,
  input  logic [1:0]       regSrc_ex,
  input  logic             halt_wb,
  output logic             pc_en,
  output logic             en_fd,
  output logic             en_de,
  output logic             en_em,
  output logic             en_mw,
  output logic             flush_fd,
  output logic             flush_de,
  output logic             halted,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  pctl_state_t      r_state;
  logic [WD_W-1:0]  r_wd_cnt;
  logic             r_mem_err;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_lu;
  logic w_dwait;
  logic w_pc_en, w_en_fd, w_en_de, w_en_em, w_en_mw;
  logic w_flush_fd, w_flush_de;

  load_use_detect u_lu (
    .regWr_ex  (regWr_ex),
    .regSrc_ex (regSrc_ex),
    .regDst_ex (regDst_ex),
    .rs_de     (rs_de),
    .rt_de     (rt_de),
    .usesRt_de (usesRt_de),
    .jr_de     (jr_de),
    .lu        (w_lu)
  );

  // The dhit cycle ends the wait, so DWAIT itself only freezes while dhit is low
  assign w_dwait = !dhit && ((r_state == DWAIT) || dmemREN_me || dmemWEN_me);

  always_comb begin
    w_pc_en    = 1'b1;
    w_en_fd    = 1'b1;
    w_en_de    = 1'b1;
    w_en_em    = 1'b1;
    w_en_mw    = 1'b1;
    w_flush_fd = 1'b0;
    w_flush_de = 1'b0;
    if (r_state == HALTED) begin
      {w_pc_en, w_en_fd, w_en_de, w_en_em, w_en_mw} = 5'b00000;
    end else if (w_dwait) begin
      {w_pc_en, w_en_fd, w_en_de, w_en_em, w_en_mw} = 5'b00000;
    end else if (w_lu) begin
      w_pc_en    = 1'b0;
      w_en_fd    = 1'b0;
      w_flush_de = 1'b1;
    end else if (branch_taken_ex) begin
      w_flush_fd = 1'b1;
      w_flush_de = 1'b1;
    end else if (jump_de) begin
      w_flush_fd = 1'b1;
    end else if (!ihit) begin
      w_pc_en    = 1'b0;
      w_flush_fd = 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state     <= RUN;
      r_wd_cnt    <= '0;
      r_mem_err   <= 1'b0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      case (r_state)
        RUN: begin
          if (w_dwait)      r_state <= DWAIT;
          else if (halt_wb) r_state <= HALTED;
        end
        DWAIT: begin
          if (dhit) r_state <= halt_wb ? HALTED : RUN;
        end
        default: r_state <= HALTED;
      endcase

      if ((r_state == DWAIT) && !dhit) begin
        if (r_wd_cnt != WD_W'(TIMEOUT)) r_wd_cnt <= r_wd_cnt + WD_W'(1);
        if (r_wd_cnt >= WD_W'(TIMEOUT - 1)) r_mem_err <= 1'b1;
      end else begin
        r_wd_cnt <= '0;
      end

      if (!w_pc_en && (r_state != HALTED) && (r_stall_cnt != {CNT_W{1'b1}}))
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if ((w_flush_fd || w_flush_de) && (r_flush_cnt != {CNT_W{1'b1}}))
        r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign pc_en     = w_pc_en;
  assign en_fd     = w_en_fd;
  assign en_de     = w_en_de;
  assign en_em     = w_en_em;
  assign en_mw     = w_en_mw;
  assign flush_fd  = w_flush_fd;
  assign flush_de  = w_flush_de;
  assign halted    = (r_state == HALTED);
  assign mem_err   = r_mem_err;
  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;
endmodule
